fpu_arbiter: RTL and testbench

Sequencer and two-port arbiter for the shared single-precision-style FPU adder (1-bit sign, 10-bit exponent, 21-bit mantissa, one-hot 4-bit status). The adder has no start/done handshake: it begins one operation each time its active-low reset is released and returns its result a fixed number of cycles later. This block accepts operand pairs from two requesters over valid/ready, arbitrates round-robin, launches the FPU with a one-cycle reset pulse, and holds operands stable for the whole operation. It then captures the result after a fixed latency and returns it to the winning requester over valid/ready.

---
 rtl/fpu_arbiter_if.sv | 39 +++
 rtl/fpu_arbiter.sv | 97 +++++++++
 tb/tb_fpu_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_arbiter_if.sv
// Bundle of requester, response and FPU-side signals shared between the
// arbiter (slave) and its environment (master: requesters plus FPU).
`timescale 1ns/1ps
interface fpu_arbiter_if;
   logic        req0_valid;
   logic        req1_valid;
   logic [31:0] req0_op_a;
   logic [31:0] req0_op_b;
   logic [31:0] req1_op_a;
   logic [31:0] req1_op_b;
   logic        req0_ready;
   logic        req1_ready;
   logic        rsp0_valid;
   logic        rsp1_valid;
   logic        rsp0_ready;
   logic        rsp1_ready;
   logic [31:0] rsp_data;
   logic [3:0]  rsp_status;
   logic        busy;
   logic        fpu_reset_n;
   logic [31:0] fpu_op_a;
   logic [31:0] fpu_op_b;
   logic [31:0] fpu_data_in;
   logic [3:0]  fpu_status_in;

   modport slave (
      input  req0_valid, req1_valid, req0_op_a, req0_op_b, req1_op_a, req1_op_b,
      input  rsp0_ready, rsp1_ready, fpu_data_in, fpu_status_in,
      output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, rsp_status,
      output busy, fpu_reset_n, fpu_op_a, fpu_op_b
   );

   modport master (
      output req0_valid, req1_valid, req0_op_a, req0_op_b, req1_op_a, req1_op_b,
      output rsp0_ready, rsp1_ready, fpu_data_in, fpu_status_in,
      input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, rsp_status,
      input  busy, fpu_reset_n, fpu_op_a, fpu_op_b
   );
endinterface

// File: rtl/fpu_arbiter.sv
// Round-robin two-port sequencer for the handshake-less FPU adder: launches it
// with a one-cycle reset pulse, captures the result after a fixed latency.
//
// state     | meaning
// S_IDLE    | waiting for a requester; grant computed combinationally
// S_LAUNCH  | fpu_reset_n held low for one cycle to start the FPU
// S_WAIT    | counting FPU latency, capture on the last count
// S_RESPOND | response valid on the granted port until consumed
`timescale 1ns/1ps
module fpu_arbiter #(
   parameter int FPU_LATENCY = 9
) (
   input logic          i_clock_100KHz,
   input logic          i_reset,
   fpu_arbiter_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESPOND} state_t;

   localparam logic [3:0] LastCnt = 4'(FPU_LATENCY - 1);

   state_t      r_state;
   state_t      w_next;
   logic        r_grant;
   logic        r_last_grant;
   logic [3:0]  r_cnt;
   logic        r_fpu_reset_n;
   logic [31:0] r_op_a;
   logic [31:0] r_op_b;
   logic [31:0] r_rsp_data;
   logic [3:0]  r_rsp_status;
   logic        w_gnt;
   logic        w_xfer;
   logic        w_rsp_take;
   logic        w_capture;

   always_ff @(posedge i_clock_100KHz) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (w_xfer) w_next = S_LAUNCH;
         S_LAUNCH:  w_next = S_WAIT;
         S_WAIT:    if (w_capture) w_next = S_RESPOND;
         S_RESPOND: if (w_rsp_take) w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_comb begin
      // On a tie the port that did not win last time gets the grant.
      w_gnt          = (bus.req0_valid && bus.req1_valid) ? ~r_last_grant : bus.req1_valid;
      bus.req0_ready = (r_state == S_IDLE) && !w_gnt && bus.req0_valid;
      bus.req1_ready = (r_state == S_IDLE) &&  w_gnt && bus.req1_valid;
      w_xfer         = bus.req0_ready || bus.req1_ready;
      bus.rsp0_valid = (r_state == S_RESPOND) && !r_grant;
      bus.rsp1_valid = (r_state == S_RESPOND) &&  r_grant;
      w_rsp_take     = (bus.rsp0_valid && bus.rsp0_ready) || (bus.rsp1_valid && bus.rsp1_ready);
      w_capture      = (r_state == S_WAIT) && (r_cnt == LastCnt);
      bus.busy       = (r_state != S_IDLE);
   end

   always_ff @(posedge i_clock_100KHz) begin
      if (i_reset) begin
         r_fpu_reset_n <= 1'b0;
         r_grant       <= 1'b0;
         r_last_grant  <= 1'b1;
         r_cnt         <= 4'd0;
         r_op_a        <= 32'd0;
         r_op_b        <= 32'd0;
         r_rsp_data    <= 32'd0;
         r_rsp_status  <= 4'd0;
      end else begin
         r_fpu_reset_n <= (w_next != S_LAUNCH);
         if (w_xfer) begin
            r_grant <= w_gnt;
            r_op_a  <= w_gnt ? bus.req1_op_a : bus.req0_op_a;
            r_op_b  <= w_gnt ? bus.req1_op_b : bus.req0_op_b;
         end
         if (r_state == S_LAUNCH)    r_cnt <= 4'd0;
         else if (r_state == S_WAIT) r_cnt <= r_cnt + 4'd1;
         if (w_capture) begin
            r_rsp_data   <= bus.fpu_data_in;
            r_rsp_status <= bus.fpu_status_in;
         end
         if (w_rsp_take) r_last_grant <= r_grant;
      end
   end

   assign bus.fpu_reset_n = r_fpu_reset_n;
   assign bus.fpu_op_a    = r_op_a;
   assign bus.fpu_op_b    = r_op_b;
   assign bus.rsp_data    = r_rsp_data;
   assign bus.rsp_status  = r_rsp_status;
endmodule

// File: tb/tb_fpu_arbiter.sv
// Bench for fpu_arbiter: stub FPU (sum of operands, valid from the 9th edge
// after launch), table-driven single ops, corner sequences, random vs. model.
`timescale 1ns/1ps
module tb_fpu_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fpu_arbiter_if bus();
   fpu_arbiter #(.FPU_LATENCY(9)) dut (.i_clock_100KHz(clk), .i_reset(rst), .bus(bus));

   logic        drv_v[2];
   logic [31:0] drv_a[2];
   logic [31:0] drv_b[2];
   logic        drv_rr[2];
   logic [3:0]  stub_status;
   logic [3:0]  stub_cnt;

   assign bus.req0_valid = drv_v[0];
   assign bus.req1_valid = drv_v[1];
   assign bus.req0_op_a  = drv_a[0];
   assign bus.req0_op_b  = drv_b[0];
   assign bus.req1_op_a  = drv_a[1];
   assign bus.req1_op_b  = drv_b[1];
   assign bus.rsp0_ready = drv_rr[0];
   assign bus.rsp1_ready = drv_rr[1];

   // Stub FPU: output meaningful only once 8 edges have seen reset_n high,
   // i.e. when sampled on the 9th edge after fpu_reset_n rises.
   always @(posedge clk) begin
      if (!bus.fpu_reset_n)    stub_cnt <= 4'd0;
      else if (stub_cnt != 15) stub_cnt <= stub_cnt + 4'd1;
   end
   assign bus.fpu_data_in   = (stub_cnt >= 8) ? bus.fpu_op_a + bus.fpu_op_b : 32'hDEADBEEF;
   assign bus.fpu_status_in = (stub_cnt >= 8) ? stub_status : 4'b1111;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic rdy(input int p);
      return (p == 1) ? bus.req1_ready : bus.req0_ready;
   endfunction

   function automatic logic rspv(input int p);
      return (p == 1) ? bus.rsp1_valid : bus.rsp0_valid;
   endfunction

   function automatic logic [3:0] rnd_status();
      case ($urandom_range(0, 4))
         0:       return 4'b0000;
         1:       return 4'b0001;
         2:       return 4'b0010;
         3:       return 4'b0100;
         default: return 4'b1000;
      endcase
   endfunction

   // ---------------- reference model state ----------------
   logic        m_busy, m_last, m_take, m_rel;
   int          m_port, m_acc, m_take_port;
   logic [31:0] m_a, m_b, cap_d;
   logic [3:0]  m_st, cap_s;
   logic        hold[2];
   int          glog[$];
   int          alog[$];

   task automatic model_reset();
      m_busy = 0; m_last = 1; m_take = 0; m_rel = 0;
      m_port = 0; m_acc = 0;
      cap_d = 0; cap_s = 0;
      hold[0] = 0; hold[1] = 0;
      glog.delete(); alog.delete();
   endtask

   task automatic do_reset();
      drv_v[0] = 0; drv_v[1] = 0; drv_rr[0] = 0; drv_rr[1] = 0;
      rst = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", bus.busy, 0);
      chk("rst_rsp0_valid", bus.rsp0_valid, 0);
      chk("rst_rsp1_valid", bus.rsp1_valid, 0);
      chk("rst_req0_ready", bus.req0_ready, 0);
      chk("rst_req1_ready", bus.req1_ready, 0);
      chk("rst_fpu_reset_n", bus.fpu_reset_n, 0);
      chk("rst_fpu_op_a", bus.fpu_op_a, 0);
      chk("rst_fpu_op_b", bus.fpu_op_b, 0);
      chk("rst_rsp_data", bus.rsp_data, 0);
      chk("rst_rsp_status", bus.rsp_status, 0);
      rst = 0;
      @(posedge clk);
      model_reset();
   endtask

   // One cycle of model-checked traffic. mode 0: random, 1: both always
   // requesting with responses always taken, 2: no new requests.
   task automatic step(input int mode);
      int   g;
      logic er[2];
      logic ev;
      @(negedge clk);
      if (m_take) begin
         m_busy = 1; m_port = m_take_port; m_acc = cyc;
         m_a = drv_a[m_port]; m_b = drv_b[m_port]; m_st = stub_status;
         hold[m_port] = 0; m_take = 0;
         glog.push_back(m_port); alog.push_back(cyc);
      end
      if (m_rel) begin
         m_busy = 0; m_last = (m_port == 1); m_rel = 0;
      end
      if (m_busy && cyc == m_acc + 10) begin
         cap_d = m_a + m_b; cap_s = m_st;
      end
      for (int p = 0; p < 2; p++) begin
         if (!hold[p]) begin
            hold[p] = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : ($urandom_range(0, 2) == 0);
            drv_a[p] = $urandom; drv_b[p] = $urandom;
         end
         drv_v[p]  = hold[p];
         drv_rr[p] = (mode == 0) ? ($urandom_range(0, 2) == 0) : 1'b1;
      end
      #1;
      g = (drv_v[0] && drv_v[1]) ? int'(!m_last) : int'(drv_v[1]);
      for (int p = 0; p < 2; p++) begin
         er[p] = !m_busy && drv_v[p] && (g == p);
         chk("req_ready", rdy(p), er[p]);
         ev = m_busy && (m_port == p) && (cyc >= m_acc + 10);
         chk("rsp_valid", rspv(p), ev);
         if (ev && drv_rr[p]) m_rel = 1;
      end
      chk("busy", bus.busy, m_busy);
      chk("fpu_reset_n", bus.fpu_reset_n, !(m_busy && cyc == m_acc));
      chk("rsp_data", bus.rsp_data, cap_d);
      chk("rsp_status", bus.rsp_status, cap_s);
      if (m_busy) begin
         chk("fpu_op_a", bus.fpu_op_a, m_a);
         chk("fpu_op_b", bus.fpu_op_b, m_b);
      end
      if (er[0] || er[1]) begin
         m_take = 1; m_take_port = er[1] ? 1 : 0;
         stub_status = rnd_status();
      end
   endtask

   // Single op on one port with nothing else going on.
   task automatic run_single(input int port, input logic [31:0] a, input logic [31:0] b,
                             input logic [3:0] st, input logic [31:0] exp_d, input logic [3:0] exp_s);
      int   got;
      logic other, opbad, rnbad;
      @(negedge clk);
      stub_status = st;
      drv_a[port] = a; drv_b[port] = b; drv_v[port] = 1;
      #1;
      chk("single_ready", rdy(port), 1);
      chk("single_other_ready", rdy(1 - port), 0);
      @(posedge clk);
      #1;
      drv_v[port] = 0;
      drv_a[port] = 32'hFFFFFFFF;
      got = -1; other = 0; opbad = 0; rnbad = 0;
      for (int k = 0; k < 40 && got < 0; k++) begin
         @(negedge clk);
         if (bus.fpu_reset_n !== (k != 0)) rnbad = 1;
         if (rspv(1 - port)) other = 1;
         if (bus.fpu_op_a !== a) opbad = 1;
         if (rspv(port)) got = k;
      end
      chk("single_latency", got, 10);
      chk("single_reset_pulse", rnbad, 0);
      chk("single_other_rsp", other, 0);
      chk("single_op_a_stable", opbad, 0);
      chk("single_data", bus.rsp_data, exp_d);
      chk("single_status", bus.rsp_status, exp_s);
      drv_rr[port] = 1;
      @(negedge clk);
      chk("single_rsp_drop", rspv(port), 0);
      chk("single_idle", bus.busy, 0);
      drv_rr[port] = 0;
   endtask

   typedef struct {
      int          port;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  st;
      logic [31:0] exp_d;
      logic [3:0]  exp_s;
   } vec_t;

   vec_t tbl[5];

   initial begin
      int   got;
      logic bad;
      drv_v[0] = 0; drv_v[1] = 0; drv_rr[0] = 0; drv_rr[1] = 0;
      drv_a[0] = 0; drv_a[1] = 0; drv_b[0] = 0; drv_b[1] = 0;
      stub_status = 4'b0001;
      model_reset();

      tbl[0] = '{0, 32'h3FE00000, 32'h00000001, 4'b0001, 32'h3FE00001, 4'b0001};
      tbl[1] = '{1, 32'h00000010, 32'h00000020, 4'b0010, 32'h00000030, 4'b0010};
      tbl[2] = '{0, 32'h12345678, 32'h11111111, 4'b0100, 32'h23456789, 4'b0100};
      tbl[3] = '{1, 32'hFFFFFFFF, 32'h00000002, 4'b1000, 32'h00000001, 4'b1000};
      tbl[4] = '{0, 32'h40000000, 32'h40000000, 4'b0000, 32'h80000000, 4'b0000};

      do_reset();
      for (int i = 0; i < 5; i++)
         run_single(tbl[i].port, tbl[i].a, tbl[i].b, tbl[i].st, tbl[i].exp_d, tbl[i].exp_s);

      // Backpressure on port 1 with port 0 waiting.
      @(negedge clk);
      stub_status = 4'b0100;
      drv_a[1] = 32'h100; drv_b[1] = 32'h200; drv_v[1] = 1;
      @(posedge clk);
      #1 drv_v[1] = 0;
      got = -1;
      for (int k = 0; k < 40 && got < 0; k++) begin
         @(negedge clk);
         if (bus.rsp1_valid) got = k;
      end
      chk("bp_latency", got, 10);
      drv_a[0] = 32'h1; drv_b[0] = 32'h2; drv_v[0] = 1;
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         #1;
         if (!bus.rsp1_valid || bus.rsp_data !== 32'h300 || bus.rsp_status !== 4'b0100 ||
             bus.req0_ready || bus.rsp0_valid) bad = 1;
      end
      chk("bp_hold", bad, 0);
      drv_rr[1] = 1;
      @(negedge clk);
      #1;
      chk("bp_next_accept", bus.req0_ready, 1);
      chk("bp_rsp1_drop", bus.rsp1_valid, 0);
      drv_rr[1] = 0;
      @(posedge clk);
      #1 drv_v[0] = 0;
      got = -1;
      for (int k = 0; k < 40 && got < 0; k++) begin
         @(negedge clk);
         if (bus.rsp0_valid) got = k;
      end
      chk("bp_next_latency", got, 10);
      chk("bp_next_data", bus.rsp_data, 32'h3);
      drv_rr[0] = 1;
      @(negedge clk);
      drv_rr[0] = 0;

      // Reset while WAIT counter is 4.
      @(negedge clk);
      stub_status = 4'b0001;
      drv_a[0] = 32'h5; drv_b[0] = 32'h6; drv_v[0] = 1;
      @(posedge clk);
      #1 drv_v[0] = 0;
      repeat (6) @(negedge clk);
      rst = 1;
      @(negedge clk);
      chk("midrst_busy", bus.busy, 0);
      chk("midrst_fpu_reset_n", bus.fpu_reset_n, 0);
      chk("midrst_rsp0", bus.rsp0_valid, 0);
      chk("midrst_rsp1", bus.rsp1_valid, 0);
      rst = 0;
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.rsp0_valid || bus.rsp1_valid || bus.busy) bad = 1;
      end
      chk("midrst_quiet", bad, 0);
      run_single(0, 32'h3FE00000, 32'h00000001, 4'b0001, 32'h3FE00001, 4'b0001);

      // Both requesters held: alternating grants at minimum spacing.
      do_reset();
      repeat (60) step(1);
      chk("tie_count", glog.size() >= 4, 1);
      for (int i = 0; i < 4; i++)
         chk("tie_grant", (i < glog.size()) ? glog[i] : -1, i % 2);
      for (int i = 1; i < 4; i++)
         chk("tie_spacing", (i < alog.size()) ? alog[i] - alog[i-1] : -1, 12);

      // Random traffic against the model.
      do_reset();
      repeat (800) step(0);
      repeat (30) step(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "timeout");
   end
endmodule
